pipelined_addsub_n: RTL and testbench
=====================================

Name: pipelined_addsub_n

Overview:
Parametrised, pipelined W-bit adder/subtractor. It is the successor to the fixed 32-bit byte-chunk ripple adder with a registered output. The operand is split into CHUNK-bit slices, and one slice is resolved per pipeline stage, so the clock period is bounded by a CHUNK-bit ripple rather than a W-bit ripple. It adds a subtract mode, a signed-overflow flag and a valid/ready handshake with backpressure, and sits between the operand-register read and result writeback.

Parameters:
W, 32, operand/result width; must be a positive multiple of CHUNK (elaboration error otherwise).
CHUNK, 8, slice width resolved per stage; 1..W.
STAGES, W/CHUNK (derived localparam, not overridable), pipeline depth in stages.

Ports:
TClk  in  1  clock, rising edge.
TRst_n  in  1  reset, asynchronous, active-low.
in_valid  in  1  operand presented.
in_ready  out  1  block accepts operand this cycle.
ra  in  W  operand A.
rb  in  W  operand B.
cin  in  1  carry-in (borrow-in when sub=1, see Behaviour).
sub  in  1  0 = add, 1 = subtract.
out_valid  out  1  result present.
out_ready  in  1  consumer takes result this cycle.
Sum  out  W  result.
Cout  out  1  carry out of MSB.
Ovf  out  1  two's-complement signed overflow.
busy  out  1  any stage holds a valid transaction.

Behaviour:
- Arithmetic: b_eff = rb XOR {W{sub}}; c_eff = cin XOR sub; {Cout,Sum} = ra + b_eff + c_eff, computed modulo 2^W.
  - sub=1, cin=0 gives ra-rb; sub=1, cin=1 gives ra-rb-1.
  - In subtract mode, Cout=1 means no borrow.
- Ovf = carry into bit W-1 XOR carry out of bit W-1.
- Accept: a transaction is accepted on a rising edge with in_valid & in_ready.
- Pipeline:
  - Stage k (k=0..STAGES-1) resolves slice k from the carry registered by stage k-1 (stage 0 uses c_eff).
  - Each stage carries forward the unresolved upper slices, the resolved lower sum bits, and its valid bit.
  - The stage STAGES-1 register is the output register.
- Latency: out_valid rises STAGES edges after acceptance, counting the accepting edge as the first. With STAGES=1 the block behaves as a single registered adder.
- Flow control:
  - advance = !out_valid | out_ready.
  - All stages shift together only when advance=1.
  - in_ready = advance; this is a combinational path from out_ready.
  - Bubbles are not collapsed.
- Throughput: one result per cycle while out_ready=1.
- Stall: while out_valid & !out_ready, Sum, Cout, Ovf and out_valid stay stable and no stage shifts. No transaction is lost or duplicated.
- Ordering: results emerge strictly in acceptance order.
- busy = OR of all stage valid bits.
- Reset (TRst_n=0, any time, including mid-stream):
  - All valid bits clear immediately; out_valid=0, busy=0.
  - Sum=0, Cout=0, Ovf=0, and all data registers are 0.
  - In-flight transactions are dropped.
  - in_ready=1 while in reset.
  - After release, no output appears until a new transaction is accepted.
- X-safety: data registers may load regardless of valid, but Sum/Cout/Ovf must not change while out_valid=0 and the pipe is stalled.
- Boundaries: ra+rb all-ones + cin=1 carries through every slice. W=CHUNK degenerates to a single stage.

Decomposition:
- Package pipelined_addsub_pkg holds:
  - OP_ADD=1'b0 and OP_SUB=1'b1.
  - A function computing STAGES from W and CHUNK, with the multiple-of check.
- Sub-module adder_chunk: CHUNK-bit ripple adder with inputs a, b, ci and outputs s, co, plus c_msb_in (carry into its MSB) for overflow. Instantiate one per stage via generate.
- Only the last instance's c_msb_in feeds Ovf.

Test Plan:
1. Reset: hold TRst_n=0 with in_valid=1 -> out_valid=0, busy=0, Sum=0, Cout=0, Ovf=0, in_ready=1; after release, nothing emerges unprompted.
2. Add carry-ripple (W=32, CHUNK=8): ra=0xFFFFFFFF, rb=0x00000001, cin=0, sub=0, out_ready=1 -> out_valid on the 4th edge after accept; Sum=0x00000000, Cout=1, Ovf=0.
3. Subtract:
   - 5-7 -> Sum=0xFFFFFFFE, Cout=0, Ovf=0.
   - 0x80000000-1 -> Sum=0x7FFFFFFF, Cout=1, Ovf=1.
   - 0x7FFFFFFF+1 (add) -> Sum=0x80000000, Cout=0, Ovf=1.
4. Streaming: 16 random back-to-back transactions, out_ready=1 -> first result at latency 4, then one per cycle, in order, matching the reference model.
5. Backpressure: during streaming, out_ready=0 for 6 cycles -> in_ready=0 throughout; Sum/Cout/Ovf stable; after resume all results arrive in order, none lost or duplicated.
6. Reset mid-flight: 3 transactions in pipe, pulse TRst_n low asynchronously between edges -> out_valid and busy drop immediately; none of the 3 results ever appear. Repeat tests 2-4 with W=16, CHUNK=4 and with W=8, CHUNK=8.

Source files
------------

// File: rtl/pipelined_addsub_pkg.sv
// Shared constants and elaboration helpers for the pipelined adder/subtractor.
// The stage count is derived from the operand and slice widths.
package pipelined_addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Returns 0 when the geometry is illegal so the top can refuse to elaborate.
  function automatic int calc_stages(input int w, input int chunk);
    if (chunk < 1 || w < chunk || (w % chunk) != 0) return 0;
    return w / chunk;
  endfunction

endpackage

// File: rtl/pipelined_addsub_n_adder_chunk.sv
// CHUNK-bit ripple-carry slice; also exposes the carry into its MSB so the
// top slice can form the signed-overflow flag.
module adder_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  always_comb begin
    // NOTE: every variable gets a default before the loop so no path can infer a latch.
    c    = '0;
    s    = '0;
    c[0] = ci;
    // NOTE: blocking assignments here, so each bit sees the carry produced just below it.
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co       = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/pipelined_addsub_n.sv
// Pipelined W-bit adder/subtractor resolving one CHUNK-bit slice per stage,
// with a valid/ready handshake where every stage shifts together.
module pipelined_addsub_n
  import pipelined_addsub_pkg::*;
#(
  parameter int W     = 32,
  parameter int CHUNK = 8
) (
  input  logic         TClk,
  input  logic         TRst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] ra,
  input  logic [W-1:0] rb,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] Sum,
  output logic         Cout,
  output logic         Ovf,
  output logic         busy
);

  localparam int STAGES = calc_stages(W, CHUNK);
  localparam int NS     = (STAGES < 1) ? 1 : STAGES;

  if (STAGES == 0) begin : g_bad_params
    $error("pipelined_addsub_n: W must be a positive multiple of CHUNK");
  end

  logic          advance;
  logic [NS-1:0] stage_v;
  logic [W-1:0]  sum_q;
  logic          cout_q;
  logic          ovf_q;
  logic          out_v_q;

  // Stalls only when a finished result is waiting for the consumer.
  assign advance  = !out_v_q | out_ready;
  assign in_ready = advance;

  // Combinational part of each stage: stage k adds slice k of whatever is left
  // of the operands, using the carry registered by the stage before it.
  for (genvar k = 0; k < NS; k++) begin : g_stage
    localparam int REM = W - k * CHUNK;
    localparam int LOW = (k + 1) * CHUNK;

    logic [REM-1:0]   rem_a;
    logic [REM-1:0]   rem_b;
    logic [LOW-1:0]   s_full;
    logic [CHUNK-1:0] s_slice;
    logic             ci;
    logic             v_in;
    logic             co;
    logic             c_msb;

    if (k == 0) begin : g_head
      assign rem_a  = ra;
      assign rem_b  = rb ^ {W{sub == OP_SUB}};
      assign ci     = cin ^ (sub == OP_SUB);
      assign v_in   = in_valid;
      assign s_full = s_slice;
    end else begin : g_body
      assign rem_a  = g_fwd[k].a_q;
      assign rem_b  = g_fwd[k].b_q;
      assign ci     = g_fwd[k].c_q;
      assign v_in   = g_fwd[k].v_q;
      assign s_full = {s_slice, g_fwd[k].s_q};
    end

    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a        (rem_a[CHUNK-1:0]),
      .b        (rem_b[CHUNK-1:0]),
      .ci       (ci),
      .s        (s_slice),
      .co       (co),
      .c_msb_in (c_msb)
    );

    // Only the top slice's MSB carry says anything about signed overflow.
    if (k != NS - 1) begin : g_mid
      logic unused_c_msb;
      assign unused_c_msb = c_msb;
    end
  end

  // Inter-stage registers: unresolved upper operand bits, resolved lower sum
  // bits, the carry between slices and the transaction's valid bit.
  for (genvar j = 1; j < NS; j++) begin : g_fwd
    localparam int REM = W - j * CHUNK;

    logic [REM-1:0]       a_q;
    logic [REM-1:0]       b_q;
    logic [j*CHUNK-1:0]   s_q;
    logic                 c_q;
    logic                 v_q;

    always_ff @(posedge TClk or negedge TRst_n) begin
      // NOTE: data registers are reset along with valid, so nothing stale survives reset.
      // NOTE: non-blocking assignments so every stage samples its predecessor's old value.
      if (!TRst_n) begin
        a_q <= '0;
        b_q <= '0;
        s_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else if (advance) begin
        a_q <= g_stage[j-1].rem_a[REM+CHUNK-1:CHUNK];
        b_q <= g_stage[j-1].rem_b[REM+CHUNK-1:CHUNK];
        s_q <= g_stage[j-1].s_full;
        c_q <= g_stage[j-1].co;
        v_q <= g_stage[j-1].v_in;
      end
    end

    assign stage_v[j-1] = v_q;
  end

  // Last stage register doubles as the output register.
  always_ff @(posedge TClk or negedge TRst_n) begin
    if (!TRst_n) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      out_v_q <= 1'b0;
    end else if (advance) begin
      sum_q   <= g_stage[NS-1].s_full;
      cout_q  <= g_stage[NS-1].co;
      ovf_q   <= g_stage[NS-1].co ^ g_stage[NS-1].c_msb;
      out_v_q <= g_stage[NS-1].v_in;
    end
  end

  assign stage_v[NS-1] = out_v_q;
  assign busy          = |stage_v;
  assign out_valid     = out_v_q;
  assign Sum           = sum_q;
  assign Cout          = cout_q;
  assign Ovf           = ovf_q;

endmodule

// File: tb/tb_pipelined_addsub_n.sv
// Drives three geometries (32/8, 16/4, 8/8) from one stimulus stream and
// checks each through its own scoreboard queue and output monitor.
module tb_pipelined_addsub_n;
  import pipelined_addsub_pkg::*;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
    bit          lat;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    logic        s;
    logic [31:0] sum;
    logic        co;
    logic        ov;
  } vec_t;

  logic        TClk = 1'b0;
  logic        TRst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] ra = '0;
  logic [31:0] rb = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        use_hand = 1'b0;
  logic [33:0] hand_exp = '0;
  bit          lat_chk = 1'b0;
  int          cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;

  logic        ir_a [3];
  logic        ov_a [3];
  logic        bz_a [3];
  logic        co_a [3];
  logic        of_a [3];
  logic [31:0] sum_a [3];

  always #5 TClk = ~TClk;
  always @(posedge TClk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  // Reference: {cout, ovf, sum} from plain wide arithmetic and sign rules.
  function automatic logic [33:0] model(input int gw, input logic [31:0] a, input logic [31:0] b,
                                        input logic c, input logic s);
    logic [63:0] mask, av, bv, full;
    logic        sa, sb, sr;
    mask = (64'd1 << gw) - 64'd1;
    av   = {32'd0, a} & mask;
    bv   = (s ? ~{32'd0, b} : {32'd0, b}) & mask;
    full = av + bv + {63'd0, c ^ s};
    sa   = av[gw-1];
    sb   = bv[gw-1];
    sr   = full[gw-1];
    return {full[gw], (sa == sb) && (sr != sa), full[31:0] & mask[31:0]};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int GW = (g == 0) ? 32 : (g == 1) ? 16 : 8;
    localparam int GC = (g == 0) ? 8 : (g == 1) ? 4 : 8;
    localparam int GS = GW / GC;

    logic [GW-1:0] sum_l;
    logic          ir, ov, co, of, bz;
    exp_t          q[$];
    exp_t          e;
    exp_t          n;
    logic [33:0]   m;
    logic          stall_prev = 1'b0;
    logic [GW+1:0] hold = '0;

    pipelined_addsub_n #(.W(GW), .CHUNK(GC)) u_dut (
      .TClk      (TClk),
      .TRst_n    (TRst_n),
      .in_valid  (in_valid),
      .in_ready  (ir),
      .ra        (ra[GW-1:0]),
      .rb        (rb[GW-1:0]),
      .cin       (cin),
      .sub       (sub),
      .out_valid (ov),
      .out_ready (out_ready),
      .Sum       (sum_l),
      .Cout      (co),
      .Ovf       (of),
      .busy      (bz)
    );

    assign ir_a[g]  = ir;
    assign ov_a[g]  = ov;
    assign bz_a[g]  = bz;
    assign co_a[g]  = co;
    assign of_a[g]  = of;
    assign sum_a[g] = 32'(sum_l);

    always @(negedge TClk) begin
      if (!TRst_n) begin
        q.delete();
        stall_prev = 1'b0;
      end else begin
        if (ov && out_ready) begin
          stall_prev = 1'b0;
          check($sformatf("w%0d_result_expected", GW), 64'(q.size() != 0), 64'd1);
          if (q.size() != 0) begin
            e = q.pop_front();
            check($sformatf("w%0d_result", GW), 64'({co, of, sum_l}),
                  64'({e.cout, e.ovf, e.sum[GW-1:0]}));
            if (e.lat) check($sformatf("w%0d_latency", GW), 64'(cyc - e.acc), 64'(GS));
          end
        end else if (ov) begin
          if (stall_prev) check($sformatf("w%0d_stall_hold", GW), 64'({co, of, sum_l}), 64'(hold));
          stall_prev = 1'b1;
          hold       = {co, of, sum_l};
        end else begin
          stall_prev = 1'b0;
        end
        if (in_valid && ir) begin
          m = model(GW, ra, rb, cin, sub);
          if (g == 0 && use_hand) m = hand_exp;
          n.sum  = m[31:0];
          n.ovf  = m[32];
          n.cout = m[33];
          n.acc  = cyc;
          n.lat  = lat_chk;
          q.push_back(n);
        end
      end
    end
  end

  // Entered and left at posedge+1; returns once the 32-bit instance accepts.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s);
    int waited;
    ra = a; rb = b; cin = c; sub = s; in_valid = 1'b1;
    waited = 0;
    @(negedge TClk);
    while (!ir_a[0] && waited < 50) begin
      waited++;
      @(negedge TClk);
    end
    if (!ir_a[0]) check("accept_timeout", 64'(ir_a[0]), 64'd1);
    @(posedge TClk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge TClk); #1; end
  endtask

  vec_t dv [9] = '{
    '{32'hFFFFFFFF, 32'h00000001, 1'b0, OP_ADD, 32'h00000000, 1'b1, 1'b0},
    '{32'h00000005, 32'h00000007, 1'b0, OP_SUB, 32'hFFFFFFFE, 1'b0, 1'b0},
    '{32'h80000000, 32'h00000001, 1'b0, OP_SUB, 32'h7FFFFFFF, 1'b1, 1'b1},
    '{32'h7FFFFFFF, 32'h00000001, 1'b0, OP_ADD, 32'h80000000, 1'b0, 1'b1},
    '{32'h12345678, 32'hEDCBA987, 1'b1, OP_ADD, 32'h00000000, 1'b1, 1'b0},
    '{32'h0000000A, 32'h00000003, 1'b1, OP_SUB, 32'h00000006, 1'b1, 1'b0},
    '{32'h00000000, 32'h00000000, 1'b0, OP_SUB, 32'h00000000, 1'b1, 1'b0},
    '{32'h00000000, 32'h00000001, 1'b0, OP_SUB, 32'hFFFFFFFF, 1'b0, 1'b0},
    '{32'h80000000, 32'h80000000, 1'b0, OP_ADD, 32'h00000000, 1'b1, 1'b1}
  };

  function automatic logic [31:0] stream_a(input int i);
    return 32'(i + 1) * 32'h9E3779B9;
  endfunction

  function automatic logic [31:0] stream_b(input int i);
    logic [31:0] a;
    a = stream_a(i);
    return {a[15:0], a[31:16]} ^ 32'h5A5A0F0F;
  endfunction

  initial begin
    // Reset held with an operand offered: nothing may be taken or shown.
    in_valid = 1'b1; ra = 32'hDEADBEEF; rb = 32'h1; out_ready = 1'b1;
    repeat (3) @(posedge TClk);
    @(negedge TClk);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("reset_flags_%0d", g), 64'({ov_a[g], bz_a[g], co_a[g], of_a[g], ir_a[g]}), 64'b00001);
      check($sformatf("reset_sum_%0d", g), 64'(sum_a[g]), 64'd0);
    end
    @(posedge TClk); #1;
    in_valid = 1'b0;
    TRst_n   = 1'b1;
    idle(8);
    @(negedge TClk);
    for (int g = 0; g < 3; g++) check($sformatf("post_reset_busy_%0d", g), 64'(bz_a[g]), 64'd0);
    @(posedge TClk); #1;

    // Directed vectors, hand-computed for the 32-bit instance.
    use_hand = 1'b1;
    lat_chk  = 1'b1;
    for (int i = 0; i < 9; i++) begin
      hand_exp = {dv[i].co, dv[i].ov, dv[i].sum};
      send(dv[i].a, dv[i].b, dv[i].c, dv[i].s);
    end
    in_valid = 1'b0;
    use_hand = 1'b0;
    idle(6);

    // Back-to-back stream with the consumer always ready.
    for (int i = 0; i < 16; i++) send(stream_a(i), stream_b(i), i[1], i[0]);
    in_valid = 1'b0;
    idle(6);

    // Stream with a six-cycle consumer stall in the middle.
    lat_chk = 1'b0;
    for (int i = 16; i < 22; i++) send(stream_a(i), stream_b(i), i[1], i[0]);
    ra = stream_a(22); rb = stream_b(22); cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    out_ready = 1'b0;
    repeat (6) begin
      @(negedge TClk);
      for (int g = 0; g < 3; g++) check($sformatf("stall_in_ready_%0d", g), 64'(ir_a[g]), 64'd0);
    end
    @(posedge TClk); #1;
    out_ready = 1'b1;
    for (int i = 22; i < 28; i++) send(stream_a(i), stream_b(i), i[1], i[0]);
    in_valid = 1'b0;
    idle(8);

    // Three in flight, then an asynchronous reset pulse between edges.
    lat_chk = 1'b1;
    for (int i = 0; i < 3; i++) send(stream_a(40 + i), stream_b(40 + i), 1'b0, 1'b0);
    in_valid = 1'b0;
    #3 TRst_n = 1'b0;
    #1;
    for (int g = 0; g < 3; g++)
      check($sformatf("async_reset_%0d", g), 64'({ov_a[g], bz_a[g]}), 64'b00);
    #2 TRst_n = 1'b1;
    idle(10);
    @(negedge TClk);
    for (int g = 0; g < 3; g++) check($sformatf("final_busy_%0d", g), 64'(bz_a[g]), 64'd0);
    check("w32_drained", 64'(g_dut[0].q.size()), 64'd0);
    check("w16_drained", 64'(g_dut[1].q.size()), 64'd0);
    check("w8_drained", 64'(g_dut[2].q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
